adder_seq32: RTL
================

# adder_seq32

Two-requester sequencer that time-shares one `adder_16bit` instance to perform 32-bit add/subtract over two passes: low half first, then high half with the carry rippled between passes. It arbitrates round-robin between two requesters and returns results on a single valid/ready response channel. It sits between the CPU's address/ALU stages and the shared 16-bit CLA datapath.

## Interface
Parameters: none (widths fixed at 32/16).
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req0_valid` in 1, `req0_ready` out 1: requester 0 handshake.
- `req0_a`, `req0_b` in 32: requester 0 operands.
- `req0_sub` in 1: requester 0 operation; 1 = a−b, 0 = a+b.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sub`: same as requester 0, for requester 1.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_id` out 1: index of the requester that issued the op.
- `rsp_sum` out 32: result.
- `rsp_cout` out 1: carry out of bit 31 (for sub: 1 = no borrow).
- `rsp_ovf` out 1: signed overflow.

## Operation
- States:
  - IDLE: arbitrate; leave to LO on accept.
  - LO: add low halves; always go to HI.
  - HI: add high halves; always go to DONE.
  - DONE: hold response; return to IDLE when `rsp_ready`=1.
- `reqN_ready` = (state==IDLE) && grant==N. Ready is combinational from state and the valids, and is never high for both requesters. Accept = `reqN_valid && reqN_ready`.
- Arbitration in IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester not granted last.
  - Round-robin pointer reset value: req0 wins the first tie.
  - The pointer updates only on accept.
- On accept, capture:
  - `opa` = `a`.
  - `opb` = `sub` ? ~`b` : `b`.
  - `cin0` = `sub`.
  - `id` = granted requester.
- Operands are sampled only at accept. A requester may drop valid or change data before being granted; nothing is recorded.
- LO pass:
  - Adder inputs: `opa[15:0]`, `opb[15:0]`, `c_in`=`cin0`.
  - Register `sum_lo`.
  - Register `c16` = G$$ | (P$$ & `cin0`).
- HI pass:
  - Adder inputs: `opa[31:16]`, `opb[31:16]`, `c_in`=`c16`.
  - Register `sum_hi`.
  - `rsp_cout` = G$$ | (P$$ & `c16`).
  - `rsp_ovf` = (`opa[31]`==`opb[31]`) && (`sum_hi[15]`!=`opa[31]`).
- Carry out is derived only from the group P$$/G$$; no 17th sum bit exists.
- Arithmetic is modulo 2^32. A carry out of bit 31 is reported only through `rsp_cout`.
- DONE:
  - `rsp_valid`=1.
  - `rsp_sum`/`rsp_id`/`rsp_cout`/`rsp_ovf` are held stable until `rsp_valid && rsp_ready`.
  - No new request is accepted while in DONE.

## Timing
- Reset (`rst_n`=0 at an edge) forces:
  - state to IDLE and the pointer to favour req0;
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0, `rsp_cout`=0, `rsp_ovf`=0.
- `reqN_ready` follows the state, so it is 0 when the state is not IDLE.
- Latency: accept at edge t → LO@t, HI@t+1, DONE@t+2. `rsp_valid` is high in the cycle after edge t+2, i.e. 3 cycles after accept.
- Throughput: with `rsp_ready` tied high, one op per 4 cycles. DONE→IDLE costs one cycle.
- Back-pressure: `rsp_ready`=0 holds DONE indefinitely, and both `reqN_ready` stay 0.
- Reset mid-op (LO/HI/DONE): the op is abandoned, no response is produced, outputs take their reset values, and the next request proceeds normally.
- An accept and a reset in the same cycle: reset wins and nothing is captured.

## Structure
- Shared package/header `cpu_pkg` holds:
  - state encoding constants IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3;
  - requester ID constants REQ0=1'b0, REQ1=1'b1.
- One sub-module: a single `adder_16bit` instance, muxed between halves by the state. There is no second adder.
- The arbiter, FSM and result registers live in `adder_seq32` itself.

## Test plan
- Carry across halves: reset, req0 add `0x0000FFFF`+`0x00000001` → `rsp_valid` 3 cycles after accept, `rsp_sum`=`0x00010000`, cout=0, ovf=0, id=0.
- Signed overflow: req1 add `0x7FFFFFFF`+`0x00000001` → `0x80000000`, ovf=1, cout=0, id=1. Also `0xFFFFFFFF`+`0x00000001` → `0x00000000`, cout=1, ovf=0.
- Subtract: `5−7` → `0xFFFFFFFE`, cout=0. `7−5` → `0x00000002`, cout=1. `0x80000000−1` → `0x7FFFFFFF`, ovf=1.
- Fairness: both valid continuously, `rsp_ready`=1 → accepted ids 0,1,0,1; ready is never high for both.
- Back-pressure: hold `rsp_ready`=0 for 5 cycles in DONE → outputs stable, no `reqN_ready`. Release → response completes, IDLE next cycle.
- Reset in HI: assert `rst_n`=0 for one edge → all outputs 0, no response. A following req0 `1+2` returns `0x00000003` normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU-side sequenced 32-bit adder.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned NIB_N  = HALF_W / NIB_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Operation captured at accept time; opb is already inverted for subtract.
  typedef struct packed {
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              cin0;
    logic              id;
  } op_t;

  typedef struct packed {
    logic              id;
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              ovf;
  } rsp_t;

endpackage

// File: rtl/adder_16bit.sv
// 16-bit carry-lookahead adder built from four 4-bit groups; exports group P/G
// so the caller derives the carry out itself (no 17th sum bit).
module adder_16bit
  import cpu_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic              c_in,
  output logic [HALF_W-1:0] sum_c,
  output logic              grp_g_c,
  output logic              grp_p_c
);

  logic [HALF_W-1:0] g;
  logic [HALF_W-1:0] p;
  logic [HALF_W-1:0] c;
  logic [NIB_N-1:0]  nib_g;
  logic [NIB_N-1:0]  nib_p;
  logic [NIB_N-1:0]  nib_cin;
  logic              acc_g;
  logic              acc_p;
  logic              carry;

  always_comb begin
    g       = a & b;
    p       = a ^ b;
    c       = '0;
    nib_g   = '0;
    nib_p   = '0;
    nib_cin = '0;
    acc_g   = 1'b0;
    acc_p   = 1'b1;
    carry   = c_in;

    // Per-nibble generate/propagate.
    for (int n = 0; n < int'(NIB_N); n++) begin
      acc_g = 1'b0;
      acc_p = 1'b1;
      for (int k = 0; k < int'(NIB_W); k++) begin
        acc_g = g[n*NIB_W+k] | (p[n*NIB_W+k] & acc_g);
        acc_p = acc_p & p[n*NIB_W+k];
      end
      nib_g[n] = acc_g;
      nib_p[n] = acc_p;
    end

    // Nibble carry-ins from the group terms, then bit carries inside each nibble.
    for (int n = 0; n < int'(NIB_N); n++) begin
      nib_cin[n] = carry;
      carry      = nib_g[n] | (nib_p[n] & carry);
    end
    for (int n = 0; n < int'(NIB_N); n++) begin
      carry = nib_cin[n];
      for (int k = 0; k < int'(NIB_W); k++) begin
        c[n*NIB_W+k] = carry;
        carry        = g[n*NIB_W+k] | (p[n*NIB_W+k] & carry);
      end
    end

    acc_g = 1'b0;
    acc_p = 1'b1;
    for (int n = 0; n < int'(NIB_N); n++) begin
      acc_g = nib_g[n] | (nib_p[n] & acc_g);
      acc_p = acc_p & nib_p[n];
    end
    grp_g_c = acc_g;
    grp_p_c = acc_p;
    sum_c   = p ^ c;
  end

endmodule

// File: rtl/adder_seq32.sv
// Two-requester round-robin sequencer doing 32-bit add/sub in two passes
// (low half, then high half) over one shared 16-bit adder.
module adder_seq32
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_sub,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_ovf
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  op_t               op_q, op_d;
  logic              c16_q, c16_d;
  logic [HALF_W-1:0] sum_lo_q, sum_lo_d;
  rsp_t              rsp_q, rsp_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              gnt_any_c;
  logic              gnt_id_c;
  logic              accept_c;
  logic [DATA_W-1:0] sel_a_c;
  logic [DATA_W-1:0] sel_b_c;
  logic              sel_sub_c;
  logic [HALF_W-1:0] add_a_c;
  logic [HALF_W-1:0] add_b_c;
  logic              add_cin_c;
  logic [HALF_W-1:0] add_sum_c;
  logic              add_g_c;
  logic              add_p_c;

  // Arbitration: a tie goes to the requester not granted last.
  always_comb begin
    gnt_any_c  = req0_valid | req1_valid;
    gnt_id_c   = (req0_valid && req1_valid) ? ~last_q :
                 (req1_valid ? REQ1 : REQ0);
    req0_ready = (state_q == IDLE) && gnt_any_c && (gnt_id_c == REQ0);
    req1_ready = (state_q == IDLE) && gnt_any_c && (gnt_id_c == REQ1);
    accept_c   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    sel_a_c    = (gnt_id_c == REQ1) ? req1_a   : req0_a;
    sel_b_c    = (gnt_id_c == REQ1) ? req1_b   : req0_b;
    sel_sub_c  = (gnt_id_c == REQ1) ? req1_sub : req0_sub;
  end

  // Adder operand mux: the high half is used only in HI.
  always_comb begin
    if (state_q == HI) begin
      add_a_c   = op_q.opa[DATA_W-1:HALF_W];
      add_b_c   = op_q.opb[DATA_W-1:HALF_W];
      add_cin_c = c16_q;
    end else begin
      add_a_c   = op_q.opa[HALF_W-1:0];
      add_b_c   = op_q.opb[HALF_W-1:0];
      add_cin_c = op_q.cin0;
    end
  end

  adder_16bit u_adder (
    .a       (add_a_c),
    .b       (add_b_c),
    .c_in    (add_cin_c),
    .sum_c   (add_sum_c),
    .grp_g_c (add_g_c),
    .grp_p_c (add_p_c)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    op_d        = op_q;
    c16_d       = c16_q;
    sum_lo_d    = sum_lo_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          op_d.opa  = sel_a_c;
          op_d.opb  = sel_sub_c ? ~sel_b_c : sel_b_c;
          op_d.cin0 = sel_sub_c;
          op_d.id   = gnt_id_c;
          last_d    = gnt_id_c;
          state_d   = LO;
        end
      end
      LO: begin
        sum_lo_d = add_sum_c;
        c16_d    = add_g_c | (add_p_c & op_q.cin0);
        state_d  = HI;
      end
      HI: begin
        rsp_d.id    = op_q.id;
        rsp_d.sum   = {add_sum_c, sum_lo_q};
        rsp_d.cout  = add_g_c | (add_p_c & c16_q);
        rsp_d.ovf   = (op_q.opa[DATA_W-1] == op_q.opb[DATA_W-1]) &&
                      (add_sum_c[HALF_W-1] != op_q.opa[DATA_W-1]);
        rsp_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= REQ1;
      op_q        <= '0;
      c16_q       <= 1'b0;
      sum_lo_q    <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      op_q        <= op_d;
      c16_q       <= c16_d;
      sum_lo_q    <= sum_lo_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_q.id;
  assign rsp_sum   = rsp_q.sum;
  assign rsp_cout  = rsp_q.cout;
  assign rsp_ovf   = rsp_q.ovf;

endmodule
